// File: rtl/demux_pkg.sv
// Shared definitions for the registered 1-to-2 output demultiplexer.
// Channel indices, slot state encoding and default widths.
package demux_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int CNT_W_DEF  = 8;

  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/demux_out_slot.sv
// One-entry output holding slot with valid/ready handshake.
// The transfer counter exists only when DEMUX_CNT_EN is defined.
module demux_out_slot
  import demux_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
`ifdef DEMUX_CNT_EN
  , parameter int CNT_W = CNT_W_DEF
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
`ifdef DEMUX_CNT_EN
  , output logic [CNT_W-1:0] cnt
`endif
);

  slot_state_e       state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              fire_s;

  // Next-state and data-load logic; a load while firing keeps the slot FULL with no bubble
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    fire_s  = (state_q == FULL) && out_ready;
    case (state_q)
      EMPTY: begin
        if (load) begin
          state_d = FULL;
        end else begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (load) begin
          state_d = FULL;
        end else if (out_ready) begin
          state_d = EMPTY;
        end else begin
          state_d = FULL;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (load) begin
      data_d = load_data;
    end else begin
      data_d = data_q;
    end
  end

  // State and data registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      data_q  <= {DATA_W{1'b0}};
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;

`ifdef DEMUX_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Transfer counter advances on each output fire and wraps naturally
  always_comb begin
    cnt_d = cnt_q;
    if (fire_s) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
`else
  logic unused_fire_s;
  assign unused_fire_s = fire_s;
`endif

endmodule

// File: rtl/eight_bit_demux_reg.sv
// Registered 1-to-2 demultiplexer steering ALU results to one of two consumers.
// Optional per-channel transfer counters are enabled with DEMUX_CNT_EN.
module eight_bit_demux_reg
  import demux_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
`ifdef DEMUX_CNT_EN
  , parameter int CNT_W = CNT_W_DEF
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              sel,
  output logic              y0_valid,
  input  logic              y0_ready,
  output logic [DATA_W-1:0] y0,
  output logic              y1_valid,
  input  logic              y1_ready,
  output logic [DATA_W-1:0] y1
`ifdef DEMUX_CNT_EN
  , output logic [CNT_W-1:0] cnt0
  , output logic [CNT_W-1:0] cnt1
`endif
);

  logic in_ready_s;
  logic accept_s;
  logic load0_s;
  logic load1_s;

  // Ready follows only the selected slot, so a stalled channel never blocks the other
  always_comb begin
    in_ready_s = 1'b0;
    accept_s   = 1'b0;
    load0_s    = 1'b0;
    load1_s    = 1'b0;
    if (sel == CH1) begin
      in_ready_s = !y1_valid || y1_ready;
    end else begin
      in_ready_s = !y0_valid || y0_ready;
    end
    accept_s = in_valid && in_ready_s;
    load0_s  = accept_s && (sel == CH0);
    load1_s  = accept_s && (sel == CH1);
  end

  assign in_ready = in_ready_s;

  demux_out_slot #(
    .DATA_W (DATA_W)
`ifdef DEMUX_CNT_EN
    , .CNT_W (CNT_W)
`endif
  ) u_slot0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load0_s),
    .load_data (in_data),
    .out_ready (y0_ready),
    .out_valid (y0_valid),
    .out_data  (y0)
`ifdef DEMUX_CNT_EN
    , .cnt     (cnt0)
`endif
  );

  demux_out_slot #(
    .DATA_W (DATA_W)
`ifdef DEMUX_CNT_EN
    , .CNT_W (CNT_W)
`endif
  ) u_slot1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load1_s),
    .load_data (in_data),
    .out_ready (y1_ready),
    .out_valid (y1_valid),
    .out_data  (y1)
`ifdef DEMUX_CNT_EN
    , .cnt     (cnt1)
`endif
  );

endmodule

// File: doc/eight_bit_demux_reg.md
Name: eight_bit_demux_reg

Overview:
- Registered 1-to-2 demultiplexer for the ALU datapath; inverse of the 2:1 operand mux.
- Steers one input data word to output channel 0 or channel 1 by `sel`.
- Each output channel has a one-entry holding register and a valid/ready handshake.
- Sits between the ALU result stage and two downstream consumers (e.g. accumulator write-back and output port).

Parameters:
- DATA_W, 8, width of data word on input and both outputs.
- CNT_W, 8, width of per-channel transfer counters (used only with DEMUX_CNT_EN).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  input word present.
- in_ready  output  1  block can accept input this cycle.
- in_data  input  DATA_W  input word.
- sel  input  1  destination: 0 -> channel 0, 1 -> channel 1; sampled with in_data.
- y0_valid  output  1  channel 0 holds a word.
- y0_ready  input  1  channel 0 consumer accepts.
- y0  output  DATA_W  channel 0 data.
- y1_valid  output  1  channel 1 holds a word.
- y1_ready  input  1  channel 1 consumer accepts.
- y1  output  DATA_W  channel 1 data.
- cnt0  output  CNT_W  channel 0 transfers (DEMUX_CNT_EN only).
- cnt1  output  CNT_W  channel 1 transfers (DEMUX_CNT_EN only).

Behaviour:
- Reset (rst_n low, asynchronous):
  - y0_valid = y1_valid = 0; y0 = y1 = 0; cnt0 = cnt1 = 0.
  - Both channels return to EMPTY immediately, including mid-transfer; held words are discarded.
- Per-channel state machine, states EMPTY and FULL:
  - EMPTY -> FULL on input accept targeting this channel.
  - FULL -> EMPTY on output fire (yN_valid & yN_ready) with no accept to this channel in the same cycle.
  - FULL -> FULL on simultaneous fire and accept: the new word is loaded and yN_valid stays 1.
  - yN_valid = (state == FULL).
- in_ready = (selected channel EMPTY) | (selected channel yN_ready). This is a combinational path from sel and yN_ready.
- Input accept: in_valid & in_ready. Only the channel named by sel is loaded on accept.
- Latency: word accepted at edge k is visible on yN with yN_valid = 1 after edge k. Exactly 1 cycle.
- Stability: while yN_valid & !yN_ready, yN holds its value. The non-selected channel is never disturbed by input traffic.
- The two channels are independent: channel 1 may be FULL and stalled while channel 0 streams at one word per cycle.
- When in_valid = 0, sel and in_data are ignored.
- A word is never duplicated across channels and never dropped except by reset.
- Both channels may fire in the same cycle.

Optional Feature:
- Macro: DEMUX_CNT_EN.
- Defined:
  - cnt0 and cnt1 exist.
  - Each increments by 1 on its channel's output fire.
  - Each wraps modulo 2^CNT_W (255 -> 0 at default).
  - Both reset to 0.
- Undefined: cnt0/cnt1 ports and their counter logic are absent. All other behaviour is identical.

Decomposition:
- Shared package demux_pkg holds:
  - DATA_W default constant.
  - Channel index constants CH0 = 0, CH1 = 1.
  - Slot state encoding EMPTY = 0, FULL = 1.
- Sub-module demux_out_slot, instantiated twice:
  - Holds one register, its state bit and optional counter.
  - Ports: clk, rst_n, load, load_data, out_ready, out_valid, out_data, cnt.
- Top level computes in_ready and per-slot load = accept & (sel == N).

Test Plan:
1. Basic routing: in_data = 8'hA5, sel = 0, y0_ready = 1 -> next cycle y0 = 8'hA5 with y0_valid = 1, y1_valid = 0. Repeat with 8'h3C, sel = 1 -> only y1 = 8'h3C.
2. Backpressure: y1_ready = 0.
   - Send 8'h11 to ch1 -> y1_valid = 1.
   - Next sel = 1 -> in_ready = 0 and y1 holds 8'h11.
   - Same cycle sel = 0 -> in_ready = 1 and ch0 loads.
3. Simultaneous fire and load: ch0 FULL with 8'h22, y0_ready = 1, accept 8'h33 to ch0 -> next cycle y0 = 8'h33, y0_valid stays 1, no bubble. Streaming 4 words gives 4 consecutive valid cycles.
4. Reset mid-operation: both channels FULL, pull rst_n low between edges -> y0_valid, y1_valid and data go to 0 immediately. After release, first accepted word appears 1 cycle later.
5. Counter wrap (DEMUX_CNT_EN): 256 fires on ch0 -> cnt0 = 0, cnt1 unchanged. A stalled cycle (y0_valid = 1, y0_ready = 0) does not increment.
